// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Takes the EX/MEM register outputs and runs byte/halfword/word loads and
// stores over a single-outstanding req/ack data bus. CTRL is stalled while
// the access is in flight. A bus that never answers is abandoned after
// TIMEOUT cycles and reported through bus_err_o.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   aluop_i             operation from EX/MEM (load/store codes, others pass through)
//   mem_addr_i          effective byte address
//   reg2_i              store source operand
//   wd_i/wreg_i/wdata_i write-back info from EX/MEM
//   stall_i             CTRL stall vector, bit 4 = MEM stage
//   wd_o/wreg_o/wdata_o write-back info to MEM/WB
//   stallreq_o          stall request to CTRL (combinational)
//   excep_o             misaligned-address flag (combinational)
//   bus_err_o           access timed out, valid in DONE
//   bus_req_o/bus_we_o/bus_addr_o/bus_sel_o/bus_wdata_o  data-bus request side
//   bus_rdata_i/bus_ack_i                               data-bus response side
module mem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  stall_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        excep_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [4:0] NOP_REG    = 5'b00000;
  localparam logic       NO_STOP    = 1'b0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [31:0]      r_ldata;

  logic        w_load, w_store, w_mem, w_half, w_word, w_mis;
  logic [31:0] w_lfmt;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall_i[5], stall_i[3:0]};

  assign w_load  = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LBU_OP) ||
                   (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) ||
                   (aluop_i == EXE_LW_OP);
  assign w_store = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_SH_OP) ||
                   (aluop_i == EXE_SW_OP);
  assign w_mem   = w_load || w_store;
  assign w_half  = (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) ||
                   (aluop_i == EXE_SH_OP);
  assign w_word  = (aluop_i == EXE_LW_OP) || (aluop_i == EXE_SW_OP);
  assign w_mis   = (w_half && mem_addr_i[0]) || (w_word && (mem_addr_i[1:0] != 2'b00));

  // Big-endian lane select: lane 3 holds the byte at offset 0.
  function automatic logic [3:0] lane_sel(input logic half, input logic word,
                                          input logic [1:0] a);
    if (word)      return 4'b1111;
    else if (half) return a[1] ? 4'b0011 : 4'b1100;
    else           return 4'b1000 >> a;
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    case (op)
      EXE_SB_OP: return {4{d[7:0]}};
      EXE_SH_OP: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [7:0] op, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = d[31:24];
      2'b01:   b = d[23:16];
      2'b10:   b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    case (op)
      EXE_LB_OP:  return {{24{b[7]}}, b};
      EXE_LBU_OP: return {24'd0, b};
      EXE_LH_OP:  return {{16{h[15]}}, h};
      EXE_LHU_OP: return {16'd0, h};
      default:    return d;
    endcase
  endfunction

  assign w_lfmt = load_fmt(aluop_i, mem_addr_i[1:0], bus_rdata_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ldata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem && !w_mis) begin
            if (bus_ack_i) begin
              if (w_load) r_ldata <= w_lfmt;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // An ack on the last allowed cycle still completes the access.
          if (bus_ack_i) begin
            if (w_load) r_ldata <= w_lfmt;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Hold the result until MEM is allowed to advance; never reissue.
          if (stall_i[4] == NO_STOP) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stallreq_o  = 1'b0;
    excep_o     = 1'b0;
    bus_err_o   = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = 32'd0;
    bus_sel_o   = 4'd0;
    bus_wdata_o = 32'd0;
    if (!rst) begin
      // Outputs are forced idle for the whole reset, dropping any live request.
      wd_o    = NOP_REG;
      wreg_o  = 1'b0;
      wdata_o = 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (w_mem) begin
            if (w_mis) begin
              excep_o = 1'b1;
              wreg_o  = 1'b0;
            end else begin
              bus_req_o   = 1'b1;
              stallreq_o  = 1'b1;
              bus_we_o    = w_store;
              bus_addr_o  = {mem_addr_i[31:2], 2'b00};
              bus_sel_o   = lane_sel(w_half, w_word, mem_addr_i[1:0]);
              bus_wdata_o = store_data(aluop_i, reg2_i);
            end
          end
        end
        S_DONE: begin
          bus_err_o = r_err;
          wreg_o    = wreg_i & ~r_err;
          if (w_load) wdata_o = r_ldata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  localparam logic [7:0] LB = 8'b11100000, LH = 8'b11100001, LW = 8'b11100011;
  localparam logic [7:0] LBU = 8'b11100100, LHU = 8'b11100101;
  localparam logic [7:0] SB = 8'b11101000, SH = 8'b11101001, SW = 8'b11101011;
  localparam logic [7:0] ADDU = 8'b00100001;

  logic        clk = 0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, bus_ack_i;
  logic [5:0]  stall_i;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, excep_o, bus_err_o, bus_req_o, bus_we_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;

  mem_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .stall_i(stall_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .excep_o(excep_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] alu;
    logic        wreg_in;
    logic [31:0] rdata;
    int          delay;      // no-ack cycles before the ack; large = never
    logic        e_excep;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    int          e_stalls;
    logic        chk_wd;
    logic [31:0] e_wdata;
    logic        e_wreg;
    logic        e_err;
  } vec_t;

  vec_t vt[14];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic [31:0] alu, input logic wr);
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; wdata_i = alu; wreg_i = wr; wd_i = 5'd9;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int n;
    v = vt[k];
    @(negedge clk);
    drive(v.op, v.addr, v.reg2, v.alu, v.wreg_in);
    bus_rdata_i = v.rdata; bus_ack_i = 0; stall_i = 6'd0;
    #1;
    chk($sformatf("v%0d excep", k), 32'(excep_o), 32'(v.e_excep));
    chk($sformatf("v%0d req", k), 32'(bus_req_o), 32'(v.e_req));
    if (v.e_req) begin
      chk($sformatf("v%0d we", k), 32'(bus_we_o), 32'(v.e_we));
      chk($sformatf("v%0d sel", k), 32'(bus_sel_o), 32'(v.e_sel));
      chk($sformatf("v%0d baddr", k), bus_addr_o, v.e_baddr);
      if (v.e_we) chk($sformatf("v%0d bwdata", k), bus_wdata_o, v.e_bwdata);
    end
    n = 0;
    while (stallreq_o === 1'b1 && n < 40) begin
      bus_ack_i = (n == v.delay);
      n++;
      @(negedge clk);
      bus_ack_i = 0;
      #1;
    end
    chk($sformatf("v%0d stalls", k), 32'(n), 32'(v.e_stalls));
    chk($sformatf("v%0d stallreq_end", k), 32'(stallreq_o), 32'd0);
    chk($sformatf("v%0d wreg", k), 32'(wreg_o), 32'(v.e_wreg));
    chk($sformatf("v%0d wd", k), 32'(wd_o), 32'd9);
    chk($sformatf("v%0d err", k), 32'(bus_err_o), 32'(v.e_err));
    if (v.chk_wd) chk($sformatf("v%0d wdata", k), wdata_o, v.e_wdata);
  endtask

  initial begin
    //        op    addr          reg2          alu           wr rdata         dly exc req we sel      baddr         bwdata        st wd? wdata        wreg err
    vt[0]  = '{LW,   32'h100, 32'h0,        32'h100,      1, 32'h12345678, 2,  0, 1, 0, 4'b1111, 32'h100, 32'h0,        3,  1, 32'h12345678, 1, 0};
    vt[1]  = '{LB,   32'h101, 32'h0,        32'h101,      1, 32'h00800000, 0,  0, 1, 0, 4'b0100, 32'h100, 32'h0,        1,  1, 32'hFFFFFF80, 1, 0};
    vt[2]  = '{LBU,  32'h101, 32'h0,        32'h101,      1, 32'h00800000, 0,  0, 1, 0, 4'b0100, 32'h100, 32'h0,        1,  1, 32'h00000080, 1, 0};
    vt[3]  = '{SH,   32'h202, 32'hDEADBEEF, 32'h202,      0, 32'h0,        0,  0, 1, 1, 4'b0011, 32'h200, 32'hBEEFBEEF, 1,  1, 32'h00000202, 0, 0};
    vt[4]  = '{LW,   32'h102, 32'h0,        32'h102,      1, 32'h0,        0,  1, 0, 0, 4'b0000, 32'h0,   32'h0,        0,  0, 32'h0,        0, 0};
    vt[5]  = '{LH,   32'h103, 32'h0,        32'h103,      1, 32'h0,        0,  1, 0, 0, 4'b0000, 32'h0,   32'h0,        0,  0, 32'h0,        0, 0};
    vt[6]  = '{LW,   32'h300, 32'h0,        32'h300,      1, 32'h0,        99, 0, 1, 0, 4'b1111, 32'h300, 32'h0,        16, 0, 32'h0,        0, 1};
    vt[7]  = '{LW,   32'h304, 32'h0,        32'h304,      1, 32'hCAFEF00D, 15, 0, 1, 0, 4'b1111, 32'h304, 32'h0,        16, 1, 32'hCAFEF00D, 1, 0};
    vt[8]  = '{LH,   32'h002, 32'h0,        32'h002,      1, 32'h12348001, 0,  0, 1, 0, 4'b0011, 32'h000, 32'h0,        1,  1, 32'hFFFF8001, 1, 0};
    vt[9]  = '{LHU,  32'h000, 32'h0,        32'h000,      1, 32'h80010000, 0,  0, 1, 0, 4'b1100, 32'h000, 32'h0,        1,  1, 32'h00008001, 1, 0};
    vt[10] = '{SB,   32'h003, 32'h000000A5, 32'h003,      0, 32'h0,        0,  0, 1, 1, 4'b0001, 32'h000, 32'hA5A5A5A5, 1,  1, 32'h00000003, 0, 0};
    vt[11] = '{SW,   32'h004, 32'h11223344, 32'h004,      1, 32'h0,        1,  0, 1, 1, 4'b1111, 32'h004, 32'h11223344, 2,  1, 32'h00000004, 1, 0};
    vt[12] = '{ADDU, 32'h0,   32'h0,        32'hAAAA5555, 1, 32'h0,        0,  0, 0, 0, 4'b0000, 32'h0,   32'h0,        0,  1, 32'hAAAA5555, 1, 0};
    vt[13] = '{LB,   32'h103, 32'h0,        32'h103,      1, 32'h000000FF, 0,  0, 1, 0, 4'b0001, 32'h100, 32'h0,        1,  1, 32'hFFFFFFFF, 1, 0};

    // Reset state, with an aligned load already on the inputs.
    rst = 0; stall_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    drive(LW, 32'h100, 32'h0, 32'h55, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", 32'(bus_req_o), 32'd0);
    chk("rst stallreq", 32'(stallreq_o), 32'd0);
    chk("rst wd", 32'(wd_o), 32'd0);
    chk("rst wreg", 32'(wreg_o), 32'd0);
    chk("rst wdata", wdata_o, 32'd0);
    chk("rst sel", 32'(bus_sel_o), 32'd0);
    @(negedge clk);
    rst = 1;
    drive(ADDU, 32'h0, 32'h0, 32'h0, 0);

    for (int k = 0; k < 14; k++) run_vec(k);

    // DONE holds under a MEM stall and ignores a late ack.
    @(negedge clk);
    drive(LW, 32'h500, 32'h0, 32'h500, 1);
    bus_rdata_i = 32'h0BADF00D; bus_ack_i = 1; stall_i = 6'b011110;
    @(negedge clk); #1;
    chk("hold stallreq", 32'(stallreq_o), 32'd0);
    chk("hold wdata", wdata_o, 32'h0BADF00D);
    bus_rdata_i = 32'hFFFFFFFF; bus_ack_i = 1;
    @(negedge clk); #1;
    chk("hold2 req", 32'(bus_req_o), 32'd0);
    chk("hold2 stallreq", 32'(stallreq_o), 32'd0);
    chk("hold2 wdata", wdata_o, 32'h0BADF00D);
    chk("hold2 wreg", 32'(wreg_o), 32'd1);
    bus_ack_i = 0; stall_i = 6'd0;
    @(negedge clk); #1;
    chk("release reissue", 32'(bus_req_o), 32'd1);
    bus_rdata_i = 32'h00000042; bus_ack_i = 1;
    @(negedge clk); #1;
    bus_ack_i = 0;
    chk("release done wdata", wdata_o, 32'h00000042);

    // Reset in the middle of a waiting access.
    @(negedge clk);
    drive(LW, 32'h600, 32'h0, 32'h600, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("mid req before", 32'(bus_req_o), 32'd1);
    rst = 0;
    #1;
    chk("mid rst req", 32'(bus_req_o), 32'd0);
    chk("mid rst stallreq", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    rst = 1;
    drive(ADDU, 32'h0, 32'h0, 32'h13572468, 1);
    #1;
    chk("post rst stallreq", 32'(stallreq_o), 32'd0);
    chk("post rst wdata", wdata_o, 32'h13572468);
    @(negedge clk); #1;
    chk("post rst idle", 32'(stallreq_o), 32'd0);
    chk("post rst req", 32'(bus_req_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
